alu_execute: RTL and testbench

Execute-stage ALU for the 32-bit MIPS core, sitting directly downstream of `ALU_Control`. It consumes the decoded instruction type and code plus the two operands and produces a registered result. Single-cycle operations complete in one clock. MULT/MULTU/DIV/DIVU run on an iterative 32-step unit that owns the HI/LO registers and stalls the pipe through `busy`.

---
 rtl/alu_execute.sv | 212 +++++++++++++++++++++
 tb/tb_alu_execute.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_execute.sv
// Execute-stage ALU: single-cycle integer ops plus an iterative 32-step
// multiply/divide unit that owns HI/LO and stalls the pipe through busy.
module alu_execute #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [1:0]       instr_type,
  input  logic [5:0]       instr_code,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       shamt,
  output logic [WIDTH-1:0] result,
  output logic             valid_out,
  output logic             overflow,
  output logic             zero,
  output logic             illegal,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t             r_state, w_state_nxt;
  logic [4:0]         r_cnt;
  logic [2*WIDTH-1:0] r_p;        // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   r_m;        // multiplicand / divisor magnitude
  logic               r_neg_lo;   // negate product / quotient at completion
  logic               r_neg_hi;   // negate remainder at completion
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic [WIDTH-1:0]   r_result;
  logic               r_valid, r_ovf, r_zero, r_ill;

  logic               w_accept, w_is_mul, w_is_div, w_md_op, w_last;
  logic [WIDTH-1:0]   w_sum, w_diff, w_res;
  logic               w_ovf, w_ill, w_hi_wr, w_lo_wr;
  logic               w_sgn, w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [WIDTH:0]     w_madd, w_trem;
  logic [WIDTH-1:0]   w_tsub;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_p_nxt, w_prod;
  logic [WIDTH-1:0]   w_hi_fin, w_lo_fin;

  assign busy      = (r_state != S_IDLE);
  assign result    = r_result;
  assign valid_out = r_valid;
  assign overflow  = r_ovf;
  assign zero      = r_zero;
  assign illegal   = r_ill;

  assign w_accept = valid_in && (r_state == S_IDLE);
  assign w_is_mul = (instr_type == 2'd0) && (instr_code == 6'h18 || instr_code == 6'h19);
  assign w_is_div = (instr_type == 2'd0) && (instr_code == 6'h1A || instr_code == 6'h1B);
  assign w_md_op  = w_is_mul || w_is_div;
  assign w_last   = (r_cnt == 5'd31);

  assign w_sum  = a + b;
  assign w_diff = a - b;

  // Single-cycle result, flags and HI/LO move decode
  always_comb begin
    w_res   = '0;
    w_ovf   = 1'b0;
    w_ill   = 1'b0;
    w_hi_wr = 1'b0;
    w_lo_wr = 1'b0;
    case (instr_type)
      2'd0: begin
        case (instr_code)
          6'h00: w_res = b << shamt;
          6'h02: w_res = b >> shamt;
          6'h03: w_res = $signed(b) >>> shamt;
          6'h04: w_res = b << a[4:0];
          6'h06: w_res = b >> a[4:0];
          6'h07: w_res = $signed(b) >>> a[4:0];
          6'h10: w_res = r_hi;
          6'h12: w_res = r_lo;
          6'h11: begin w_res = a; w_hi_wr = 1'b1; end
          6'h13: begin w_res = a; w_lo_wr = 1'b1; end
          6'h18, 6'h19, 6'h1A, 6'h1B: w_res = '0;  // handled by the iterative unit
          6'h20: begin w_res = w_sum;  w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]); end
          6'h21: w_res = w_sum;
          6'h22: begin w_res = w_diff; w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]); end
          6'h23: w_res = w_diff;
          6'h24: w_res = a & b;
          6'h25: w_res = a | b;
          6'h26: w_res = a ^ b;
          6'h27: w_res = ~(a | b);
          6'h2A: w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
          6'h2B: w_res = {{(WIDTH-1){1'b0}}, (a < b)};
          default: w_ill = 1'b1;
        endcase
      end
      2'd1: begin
        case (instr_code)
          6'h04, 6'h05, 6'h06, 6'h07: w_res = w_diff;  // branch compare, zero drives BEQ/BNE
          6'h08: begin w_res = w_sum; w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]); end
          6'h09: w_res = w_sum;
          6'h0A: w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
          6'h0B: w_res = {{(WIDTH-1){1'b0}}, (a < b)};
          6'h0C: w_res = a & {16'h0, b[15:0]};
          6'h0D: w_res = a | {16'h0, b[15:0]};
          6'h0E: w_res = a ^ {16'h0, b[15:0]};
          6'h0F: w_res = {b[15:0], 16'h0};
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
          6'h26, 6'h27, 6'h28, 6'h29, 6'h2A, 6'h2B: w_res = w_sum;  // load/store address
          default: w_ill = 1'b1;
        endcase
      end
      2'd2:    w_res = '0;
      default: w_ill = 1'b1;
    endcase
  end

  // Operand magnitudes for the iterative unit; a zero divisor keeps the raw dividend and no signs
  assign w_sgn   = !instr_code[0] && !(w_is_div && (b == '0));
  assign w_a_neg = w_sgn && a[WIDTH-1];
  assign w_b_neg = w_sgn && b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -a : a;
  assign w_b_mag = w_b_neg ? -b : b;

  // One shift-add or restoring-subtract step per cycle
  always_comb begin
    w_madd = r_p[0] ? ({1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, r_m}) : {1'b0, r_p[2*WIDTH-1:WIDTH]};
    w_trem = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
    w_ge   = (w_trem >= {1'b0, r_m});
    w_tsub = w_trem[WIDTH-1:0] - r_m;
    if (r_state == S_MUL)
      w_p_nxt = {w_madd, r_p[WIDTH-1:1]};
    else
      w_p_nxt = {(w_ge ? w_tsub : w_trem[WIDTH-1:0]), r_p[WIDTH-2:0], w_ge};
    w_prod = r_neg_lo ? -w_p_nxt : w_p_nxt;
    if (r_state == S_MUL) begin
      w_hi_fin = w_prod[2*WIDTH-1:WIDTH];
      w_lo_fin = w_prod[WIDTH-1:0];
    end else begin
      w_hi_fin = r_neg_hi ? -w_p_nxt[2*WIDTH-1:WIDTH] : w_p_nxt[2*WIDTH-1:WIDTH];
      w_lo_fin = r_neg_lo ? -w_p_nxt[WIDTH-1:0] : w_p_nxt[WIDTH-1:0];
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_mul)      w_state_nxt = S_MUL;
        else if (w_accept && w_is_div) w_state_nxt = S_DIV;
      end
      S_MUL, S_DIV: if (w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers: result/flags, HI/LO and the iterative unit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_p      <= '0;
      r_m      <= '0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
      r_ill    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
      r_ill   <= 1'b0;
      if (w_accept && !w_md_op) begin
        r_result <= w_res;
        r_valid  <= 1'b1;
        r_ovf    <= w_ovf;
        r_ill    <= w_ill;
        r_zero   <= (w_res == '0);
        if (w_hi_wr) r_hi <= a;
        if (w_lo_wr) r_lo <= a;
      end
      if (w_accept && w_md_op) begin
        r_cnt    <= '0;
        r_p      <= {{WIDTH{1'b0}}, w_a_mag};
        r_m      <= w_b_mag;
        r_neg_lo <= w_a_neg ^ w_b_neg;
        r_neg_hi <= w_a_neg;
      end
      if (r_state != S_IDLE) begin
        r_p   <= w_p_nxt;
        r_cnt <= r_cnt + 5'd1;
        if (w_last) begin
          r_hi     <= w_hi_fin;
          r_lo     <= w_lo_fin;
          r_result <= w_lo_fin;
          r_valid  <= 1'b1;
          r_zero   <= (w_lo_fin == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_execute.sv
// Bench for alu_execute: directed corner cases then random ops vs. an
// arithmetic reference model holding its own HI/LO.
module tb_alu_execute;
  logic        clk = 1'b0, rst_n = 1'b1, valid_in = 1'b0;
  logic [1:0]  instr_type = '0;
  logic [5:0]  instr_code = '0;
  logic [31:0] a = '0, b = '0;
  logic [4:0]  shamt = '0;
  logic [31:0] result;
  logic        valid_out, overflow, zero, illegal, busy;

  int          n_chk = 0, n_err = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  logic [5:0] rcodes [24] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h11,
                              6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h20, 6'h21,
                              6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
  logic [5:0] icodes [26] = '{6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B,
                              6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h10, 6'h20, 6'h21, 6'h22,
                              6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h28, 6'h29, 6'h2A,
                              6'h2B, 6'h11};

  alu_execute #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .instr_type(instr_type),
    .instr_code(instr_code), .a(a), .b(b), .shamt(shamt), .result(result),
    .valid_out(valid_out), .overflow(overflow), .zero(zero), .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic ovf32(input longint s);
    int si;
    si = int'(s);
    return longint'(si) != s;
  endfunction

  // Reference model; updates m_hi/m_lo for moves and mul/div
  task automatic model(input logic [1:0] t, input logic [5:0] c, input logic [31:0] va, vb,
                       input logic [4:0] sh, output logic [31:0] res, output logic ovf,
                       output logic ill, output logic md);
    logic signed [31:0] sb;
    logic [63:0] p;
    longint q, r;
    sb = vb; res = '0; ovf = 1'b0; ill = 1'b0; md = 1'b0;
    if (t == 2'd0) begin
      case (c)
        6'h00: res = vb << sh;
        6'h02: res = vb >> sh;
        6'h03: res = sb >>> sh;
        6'h04: res = vb << va[4:0];
        6'h06: res = vb >> va[4:0];
        6'h07: res = sb >>> va[4:0];
        6'h10: res = m_hi;
        6'h12: res = m_lo;
        6'h11: begin m_hi = va; res = va; end
        6'h13: begin m_lo = va; res = va; end
        6'h20, 6'h21: begin
          res = va + vb;
          ovf = (c == 6'h20) && ovf32(longint'($signed(va)) + longint'($signed(vb)));
        end
        6'h22, 6'h23: begin
          res = va - vb;
          ovf = (c == 6'h22) && ovf32(longint'($signed(va)) - longint'($signed(vb)));
        end
        6'h24: res = va & vb;
        6'h25: res = va | vb;
        6'h26: res = va ^ vb;
        6'h27: res = ~(va | vb);
        6'h2A: res = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
        6'h2B: res = (va < vb) ? 32'd1 : 32'd0;
        6'h18: begin p = longint'($signed(va)) * longint'($signed(vb)); {m_hi, m_lo} = p; md = 1'b1; end
        6'h19: begin p = {32'h0, va} * {32'h0, vb}; {m_hi, m_lo} = p; md = 1'b1; end
        6'h1A, 6'h1B: begin
          md = 1'b1;
          if (vb == 0) begin m_lo = 32'hFFFFFFFF; m_hi = va; end
          else begin
            if (c == 6'h1A) begin
              q = longint'($signed(va)) / longint'($signed(vb));
              r = longint'($signed(va)) % longint'($signed(vb));
            end else begin
              q = longint'({32'h0, va}) / longint'({32'h0, vb});
              r = longint'({32'h0, va}) % longint'({32'h0, vb});
            end
            p = q; m_lo = p[31:0];
            p = r; m_hi = p[31:0];
          end
        end
        default: ill = 1'b1;
      endcase
      if (md) res = m_lo;
    end else if (t == 2'd1) begin
      if (c >= 6'h04 && c <= 6'h07) res = va - vb;
      else if (c >= 6'h20 && c <= 6'h2B) res = va + vb;
      else case (c)
        6'h08: begin res = va + vb; ovf = ovf32(longint'($signed(va)) + longint'($signed(vb))); end
        6'h09: res = va + vb;
        6'h0A: res = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
        6'h0B: res = (va < vb) ? 32'd1 : 32'd0;
        6'h0C: res = va & {16'h0, vb[15:0]};
        6'h0D: res = va | {16'h0, vb[15:0]};
        6'h0E: res = va ^ {16'h0, vb[15:0]};
        6'h0F: res = {vb[15:0], 16'h0};
        default: ill = 1'b1;
      endcase
    end else if (t == 2'd3) begin
      ill = 1'b1;
    end
  endtask

  // Issue one op and check its outcome
  task automatic run(input logic [1:0] t, input logic [5:0] c, input logic [31:0] va, vb,
                     input logic [4:0] sh);
    logic [31:0] er;
    logic eo, ei, emd;
    int n;
    string tg;
    tg = $sformatf("t%0d_c%02h", t, c);
    @(negedge clk);
    instr_type = t; instr_code = c; a = va; b = vb; shamt = sh; valid_in = 1'b1;
    model(t, c, va, vb, sh, er, eo, ei, emd);
    @(posedge clk); #1;
    valid_in = 1'b0;
    if (emd) begin
      chk({tg, "_busy"}, 64'(busy), 64'd1);
      n = 0;
      while (!valid_out && n < 40) begin @(posedge clk); #1; n++; end
      chk({tg, "_lat"}, 64'(n), 64'd32);
      chk({tg, "_busy_clr"}, 64'(busy), 64'd0);
    end else begin
      chk({tg, "_vout"}, 64'(valid_out), 64'd1);
      chk({tg, "_ovf"}, 64'(overflow), 64'(eo));
      chk({tg, "_ill"}, 64'(illegal), 64'(ei));
    end
    chk({tg, "_res"}, 64'(result), 64'(er));
    chk({tg, "_zero"}, 64'(zero), 64'(er == 0));
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'h7FFFFFFF;
      4: return 32'($urandom_range(0, 9));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    logic [31:0] er, hold;
    logic eo, ei, emd;
    logic [1:0] t;
    logic [5:0] c;
    int pulses, done_at;

    #2 rst_n = 1'b0;
    #20;
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_flags", 64'({overflow, zero, illegal}), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    run(2'd0, 6'h10, 32'h0, 32'h0, 5'd0);                   // MFHI after reset
    run(2'd0, 6'h20, 32'h7FFFFFFF, 32'h1, 5'd0);            // ADD overflow
    @(posedge clk); #1;
    chk("idle_valid", 64'(valid_out), 64'd0);
    chk("idle_ovf", 64'(overflow), 64'd0);
    chk("idle_hold", 64'(result), 64'h80000000);

    // MULTU with an ADD pulsed mid-operation that must be ignored
    @(negedge clk);
    instr_type = 2'd0; instr_code = 6'h19; a = 32'hFFFFFFFF; b = 32'h2; valid_in = 1'b1;
    model(2'd0, 6'h19, 32'hFFFFFFFF, 32'h2, 5'd0, er, eo, ei, emd);
    @(posedge clk); #1 valid_in = 1'b0;
    pulses = 0; done_at = 0;
    for (int k = 1; k <= 36; k++) begin
      @(posedge clk); #1;
      if (k == 3) begin instr_code = 6'h20; a = 32'h5; b = 32'h6; valid_in = 1'b1; end
      if (k == 4) valid_in = 1'b0;
      if (valid_out) begin pulses++; done_at = k; end
    end
    chk("busy_pulses", 64'(pulses), 64'd1);
    chk("busy_done_at", 64'(done_at), 64'd32);
    chk("multu_res", 64'(result), 64'hFFFFFFFE);
    run(2'd0, 6'h10, 32'h0, 32'h0, 5'd0);
    run(2'd0, 6'h12, 32'h0, 32'h0, 5'd0);

    run(2'd0, 6'h1A, 32'hFFFFFFF9, 32'h2, 5'd0);            // DIV -7/2
    run(2'd0, 6'h10, 32'h0, 32'h0, 5'd0);
    run(2'd0, 6'h12, 32'h0, 32'h0, 5'd0);
    run(2'd0, 6'h1B, 32'h5, 32'h0, 5'd0);                   // DIVU by zero
    run(2'd0, 6'h10, 32'h0, 32'h0, 5'd0);
    run(2'd0, 6'h1A, 32'h80000000, 32'hFFFFFFFF, 5'd0);     // min / -1
    run(2'd0, 6'h10, 32'h0, 32'h0, 5'd0);
    run(2'd0, 6'h1A, 32'hFFFFFFF0, 32'h0, 5'd0);            // signed DIV by zero
    run(2'd0, 6'h10, 32'h0, 32'h0, 5'd0);
    run(2'd0, 6'h18, 32'hFFFFFFFD, 32'h7, 5'd0);            // MULT -3*7
    run(2'd0, 6'h10, 32'h0, 32'h0, 5'd0);
    run(2'd1, 6'h0D, 32'hF0000000, 32'hFFFF8001, 5'd0);     // ORI
    run(2'd1, 6'h0F, 32'h0, 32'h1234, 5'd0);                // LUI
    run(2'd1, 6'h11, 32'h1, 32'h2, 5'd0);                   // coprocessor -> illegal
    run(2'd2, 6'h02, 32'h1, 32'h2, 5'd0);                   // J

    // MTHI then MFHI back-to-back
    hold = 32'hA5A5_0F0F;
    @(negedge clk);
    instr_type = 2'd0; instr_code = 6'h11; a = hold; valid_in = 1'b1;
    @(negedge clk);
    instr_code = 6'h10; a = 32'h0;
    @(posedge clk); #1 valid_in = 1'b0;
    chk("mthi_mfhi", 64'(result), 64'(hold));
    m_hi = hold;

    // Reset in the middle of a DIV
    @(negedge clk);
    instr_type = 2'd0; instr_code = 6'h1B; a = 32'd100; b = 32'd3; valid_in = 1'b1;
    @(posedge clk); #1 valid_in = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstdiv_busy", 64'(busy), 64'd0);
    chk("rstdiv_valid", 64'(valid_out), 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk) rst_n = 1'b1;
    pulses = 0;
    repeat (30) begin @(posedge clk); #1; if (valid_out) pulses++; end
    chk("rstdiv_no_vout", 64'(pulses), 64'd0);
    run(2'd0, 6'h10, 32'h0, 32'h0, 5'd0);
    run(2'd0, 6'h12, 32'h0, 32'h0, 5'd0);

    // Random ops against the model
    for (int i = 0; i < 400; i++) begin
      t = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0)
        c = (t == 2'd1) ? icodes[$urandom_range(0, 25)] : rcodes[$urandom_range(0, 23)];
      else
        c = 6'($urandom_range(0, 63));
      run(t, c, rnd32(), rnd32(), 5'($urandom_range(0, 31)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
    $finish;
  end

endmodule
